// File: rtl/led_pwm_pkg.sv
// -----------------------------------------------------------------------------
// led_pwm_pkg
// Shared types for the LED/GPIO PWM controller.
//   led_mode_t : per-channel output mode (OFF, ON, PWM dimming, BLINK)
//   ch_cfg_t   : one channel's configuration word {mode, level, period}
//   ch_width() : index width for a channel count (never below 1 bit)
// The struct fields are sized by CFG_LEVEL_W / CFG_PERIOD_W. Those are the
// largest PWM_BITS / BLINK_BITS a controller instance may use. Narrower
// instances zero-extend into the fields and only read back the low bits.
// -----------------------------------------------------------------------------
package led_pwm_pkg;

    localparam int CFG_LEVEL_W  = 8;
    localparam int CFG_PERIOD_W = 16;

    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_PWM   = 2'd2,
        LED_BLINK = 2'd3
    } led_mode_t;

    typedef struct packed {
        led_mode_t                mode;
        logic [CFG_LEVEL_W-1:0]   level;
        logic [CFG_PERIOD_W-1:0]  period;
    } ch_cfg_t;

    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/led_pwm_ctrl_if.sv
// -----------------------------------------------------------------------------
// led_pwm_ctrl_if
// Configuration write port of the LED PWM controller (valid/ready).
//   cfg_valid  : write request, held by the master until accepted
//   cfg_ready  : controller can take a write this cycle
//   cfg_ch     : target channel index
//   cfg_mode   : 0=OFF 1=ON 2=PWM 3=BLINK
//   cfg_level  : PWM duty level
//   cfg_period : blink half-period in frames, minus 1
//   cfg_err    : one-cycle pulse after a write to a non-existent channel
// Modports: master (register shim side), slave (controller side).
// -----------------------------------------------------------------------------
interface led_pwm_ctrl_if
    import led_pwm_pkg::*;
#(
    parameter int NUM_CH     = 8,
    parameter int PWM_BITS   = 8,
    parameter int BLINK_BITS = 16
);

    localparam int CH_W = ch_width(NUM_CH);

    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [CH_W-1:0]       cfg_ch;
    logic [1:0]            cfg_mode;
    logic [PWM_BITS-1:0]   cfg_level;
    logic [BLINK_BITS-1:0] cfg_period;
    logic                  cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_mode, cfg_level, cfg_period,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_mode, cfg_level, cfg_period,
        output cfg_ready, cfg_err
    );

endinterface

// File: rtl/led_pwm_chan.sv
// -----------------------------------------------------------------------------
// led_pwm_chan
// One output channel: shadow and active configuration, blink counter and
// phase, and the registered output compare.
//   clk, reset  : clock, synchronous active-high reset
//   wr_en       : load wr_cfg into the shadow register
//   wr_cfg      : configuration word from the write port
//   frame_wrap  : pwm_cnt wraps to 0 on this clock edge
//   pwm_cnt     : shared frame position counter
//   led         : registered channel output
// Optional build macro LED_PWM_CTRL_GAMMA_EN squares the duty level
// (perceptual dimming); without it the level is used as-is.
// PWM_BITS / BLINK_BITS must not exceed CFG_LEVEL_W / CFG_PERIOD_W.
// -----------------------------------------------------------------------------
module led_pwm_chan
    import led_pwm_pkg::*;
#(
    parameter int PWM_BITS   = 8,
    parameter int BLINK_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  ch_cfg_t             wr_cfg,
    input  logic                frame_wrap,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led
);

    ch_cfg_t               shadow;
    ch_cfg_t               active;
    logic [BLINK_BITS-1:0] blink_cnt;
    logic                  blink_phase;

    logic [PWM_BITS-1:0]   level;
    logic [PWM_BITS-1:0]   eff_level;
    logic [BLINK_BITS-1:0] period;
    logic                  cfg_changed;
    logic                  led_next;
    logic                  unused_level_bits;

    assign level  = active.level[PWM_BITS-1:0];
    assign period = active.period[BLINK_BITS-1:0];

    // High bits of the level field stay zero for narrow instances.
    assign unused_level_bits = ^(active.level >> PWM_BITS);

`ifdef LED_PWM_CTRL_GAMMA_EN
    // Square the level in a double-width product and keep the upper half.
    logic [2*PWM_BITS-1:0] level_sq;
    assign level_sq  = {{PWM_BITS{1'b0}}, level} * {{PWM_BITS{1'b0}}, level};
    assign eff_level = PWM_BITS'(level_sq >> PWM_BITS);
`else
    assign eff_level = level;
`endif

    // A blink sequence restarts only when mode or period changes.
    // A level-only change keeps the running blink rhythm.
    assign cfg_changed = (shadow.mode != active.mode) ||
                         (shadow.period != active.period);

    // Output decode. PWM tops out one tick short of full-on, so a steady
    // 1 is only available in ON mode.
    always_comb begin
        led_next = 1'b0;
        case (active.mode)
            LED_OFF:   led_next = 1'b0;
            LED_ON:    led_next = 1'b1;
            LED_PWM:   led_next = (pwm_cnt < eff_level);
            LED_BLINK: led_next = blink_phase && (pwm_cnt < eff_level);
            default:   led_next = 1'b0;
        endcase
    end

    // Shadow takes writes at any time. Active, blink counter and phase move
    // only on a frame wrap, so the output never changes mid-frame. A write
    // on the wrap cycle lands in the shadow after the copy, so it waits one
    // more frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow      <= '0;
            active      <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            led         <= 1'b0;
        end else begin
            if (frame_wrap) begin
                active <= shadow;
                if (cfg_changed) begin
                    blink_cnt   <= '0;
                    blink_phase <= 1'b1;
                end else if (blink_cnt == period) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + BLINK_BITS'(1);
                end
            end
            if (wr_en) begin
                shadow <= wr_cfg;
            end
            led <= led_next;
        end
    end

endmodule

// File: rtl/led_pwm_ctrl.sv
// -----------------------------------------------------------------------------
// led_pwm_ctrl
// Multi-channel LED/GPIO output controller with OFF / ON / PWM / BLINK modes.
// New settings take effect together at the next PWM frame boundary.
//   clk, reset  : clock, synchronous active-high reset
//   cfg         : configuration write port (led_pwm_ctrl_if.slave)
//   frame_start : one-cycle pulse on the first tick of each PWM frame
//   led         : registered channel outputs
// Optional build macro LED_PWM_CTRL_GAMMA_EN enables gamma-squared dimming
// in every channel. The handshake and timing are the same in both builds.
// -----------------------------------------------------------------------------
module led_pwm_ctrl
    import led_pwm_pkg::*;
#(
    parameter int NUM_CH     = 8,
    parameter int PWM_BITS   = 8,
    parameter int PRESCALE   = 100,
    parameter int BLINK_BITS = 16
) (
    input  logic              clk,
    input  logic              reset,
    led_pwm_ctrl_if.slave     cfg,
    output logic              frame_start,
    output logic [NUM_CH-1:0] led
);

    localparam int CH_W  = ch_width(NUM_CH);
    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [PRE_W-1:0] PRESC_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [CH_W:0]    NUM_CH_V   = (CH_W + 1)'(NUM_CH);

    logic [PRE_W-1:0]    presc_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                tick;
    logic                frame_wrap;
    logic                accept;
    logic                ch_in_range;
    logic                ready_q;
    logic                err_q;
    ch_cfg_t             wr_cfg;

    assign tick        = (presc_cnt == PRESC_LAST);
    assign frame_wrap  = tick && (pwm_cnt == '1);
    assign accept      = cfg.cfg_valid && ready_q;
    assign ch_in_range = ({1'b0, cfg.cfg_ch} < NUM_CH_V);

    assign cfg.cfg_ready = ready_q;
    assign cfg.cfg_err   = err_q;

    // Prescaler and frame position. frame_start is the registered copy of the
    // wrap so it lines up with the first cycle where pwm_cnt reads 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_cnt   <= '0;
            pwm_cnt     <= '0;
            frame_start <= 1'b0;
        end else begin
            presc_cnt <= tick ? '0 : presc_cnt + PRE_W'(1);
            if (tick) begin
                pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            end
            frame_start <= frame_wrap;
        end
    end

    // Write handshake. Each accept spends one cycle with ready low (commit).
    // Out-of-range channels are still accepted, so the master is never stuck;
    // they only raise cfg_err on the following cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= !accept;
            err_q   <= accept && !ch_in_range;
        end
    end

    // Widen the port fields into the shared configuration word.
    always_comb begin
        wr_cfg        = '0;
        wr_cfg.mode   = led_mode_t'(cfg.cfg_mode);
        wr_cfg.level  = CFG_LEVEL_W'(cfg.cfg_level);
        wr_cfg.period = CFG_PERIOD_W'(cfg.cfg_period);
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        logic wr_en;
        assign wr_en = accept && ch_in_range && (cfg.cfg_ch == CH_W'(c));

        led_pwm_chan #(
            .PWM_BITS   (PWM_BITS),
            .BLINK_BITS (BLINK_BITS)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .wr_en      (wr_en),
            .wr_cfg     (wr_cfg),
            .frame_wrap (frame_wrap),
            .pwm_cnt    (pwm_cnt),
            .led        (led[c])
        );
    end

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_pwm_ctrl
// Random configuration writes against a frame-level reference model of the
// LED PWM controller. The model works from elapsed clock counts: the frame
// position is derived from the cycle count, and the blink phase comes from
// the number of frames since the channel's blink setting last changed.
// NUM_CH=5 leaves channel indices 5..7 free for out-of-range writes.
// -----------------------------------------------------------------------------
module tb_led_pwm_ctrl;
    import led_pwm_pkg::*;

    localparam int NUM_CH      = 5;
    localparam int PWM_BITS    = 4;
    localparam int PRESCALE    = 3;
    localparam int BLINK_BITS  = 4;
    localparam int CH_W        = ch_width(NUM_CH);
    localparam int FRAME_TICKS = 1 << PWM_BITS;
    localparam int FRAME_CYC   = PRESCALE * FRAME_TICKS;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              frame_start;
    logic [NUM_CH-1:0] led;

    led_pwm_ctrl_if #(
        .NUM_CH     (NUM_CH),
        .PWM_BITS   (PWM_BITS),
        .BLINK_BITS (BLINK_BITS)
    ) bus ();

    led_pwm_ctrl #(
        .NUM_CH     (NUM_CH),
        .PWM_BITS   (PWM_BITS),
        .PRESCALE   (PRESCALE),
        .BLINK_BITS (BLINK_BITS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg         (bus),
        .frame_start (frame_start),
        .led         (led)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state: what the outputs should read this cycle, plus the
    // committed (active) and pending (shadow) settings of each channel.
    int              k = 0;
    bit              exp_ready = 1'b0;
    bit              exp_err = 1'b0;
    bit              exp_fs = 1'b0;
    bit [NUM_CH-1:0] exp_led = '0;
    int              sh_mode[NUM_CH];
    int              sh_level[NUM_CH];
    int              sh_period[NUM_CH];
    int              ac_mode[NUM_CH];
    int              ac_level[NUM_CH];
    int              ac_period[NUM_CH];
    int              start_frame[NUM_CH];
    bit              last_accept = 1'b0;

    // Pending write held on the bus until the model sees it accepted.
    bit pend_valid = 1'b0;
    int pend_ch = 0;
    int pend_mode = 0;
    int pend_level = 0;
    int pend_period = 0;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    function automatic int effLevel(input int lvl);
`ifdef LED_PWM_CTRL_GAMMA_EN
        return (lvl * lvl) >> PWM_BITS;
`else
        return lvl;
`endif
    endfunction

    // Channel output as it should be computed during the current cycle.
    function automatic bit chanLevel(input int c);
        int  pos;
        int  frame;
        bit  phase_on;
        pos   = (k / PRESCALE) % FRAME_TICKS;
        frame = k / FRAME_CYC;
        case (ac_mode[c])
            0: return 1'b0;
            1: return 1'b1;
            2: return pos < effLevel(ac_level[c]);
            default: begin
                phase_on = (((frame - start_frame[c]) / (ac_period[c] + 1)) % 2) == 0;
                return phase_on && (pos < effLevel(ac_level[c]));
            end
        endcase
    endfunction

    // Advance the model across one rising edge given the inputs on the bus.
    task automatic modelStep(input bit rst);
        bit              wrap;
        bit [NUM_CH-1:0] nled;
        last_accept = 1'b0;
        if (rst) begin
            k = 0;
            exp_ready = 1'b0;
            exp_err = 1'b0;
            exp_fs = 1'b0;
            exp_led = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                sh_mode[c] = 0;  sh_level[c] = 0;  sh_period[c] = 0;
                ac_mode[c] = 0;  ac_level[c] = 0;  ac_period[c] = 0;
                start_frame[c] = 0;
            end
            return;
        end
        wrap = ((k + 1) % FRAME_CYC) == 0;
        last_accept = pend_valid && exp_ready;
        for (int c = 0; c < NUM_CH; c++) begin
            nled[c] = chanLevel(c);
        end
        exp_led   = nled;
        exp_fs    = wrap;
        exp_err   = last_accept && (pend_ch >= NUM_CH);
        exp_ready = !last_accept;
        if (wrap) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (sh_mode[c] != ac_mode[c] || sh_period[c] != ac_period[c]) begin
                    start_frame[c] = (k + 1) / FRAME_CYC;
                end
                ac_mode[c]   = sh_mode[c];
                ac_level[c]  = sh_level[c];
                ac_period[c] = sh_period[c];
            end
        end
        if (last_accept && pend_ch < NUM_CH) begin
            sh_mode[pend_ch]   = pend_mode;
            sh_level[pend_ch]  = pend_level;
            sh_period[pend_ch] = pend_period;
        end
        k++;
    endtask

    // Choose and drive this cycle's write. Writes are biased onto the wrap
    // cycle so the "lands one frame late" case is exercised regularly.
    task automatic applyStimulus(input bit rst);
        bit next_wrap;
        if (rst) begin
            pend_valid = 1'b0;
        end else if (!pend_valid) begin
            next_wrap = ((k + 1) % FRAME_CYC) == 0;
            if ((next_wrap && exp_ready && $urandom_range(0, 1) == 1) ||
                $urandom_range(0, 9) == 0) begin
                pend_valid  = 1'b1;
                pend_ch     = $urandom_range(0, 6);
                pend_mode   = $urandom_range(0, 3);
                pend_level  = $urandom_range(0, FRAME_TICKS - 1);
                pend_period = $urandom_range(0, 3);
            end
        end
        bus.cfg_valid  = pend_valid;
        bus.cfg_ch     = CH_W'(pend_ch);
        bus.cfg_mode   = 2'(pend_mode);
        bus.cfg_level  = PWM_BITS'(pend_level);
        bus.cfg_period = BLINK_BITS'(pend_period);
    endtask

    task automatic checkAll();
        checkOutput("cfg_ready", int'(bus.cfg_ready), int'(exp_ready));
        checkOutput("cfg_err", int'(bus.cfg_err), int'(exp_err));
        checkOutput("frame_start", int'(frame_start), int'(exp_fs));
        checkOutput("led", int'(led), int'(exp_led));
    endtask

    // One cycle: check at the falling edge, then set up the next rising edge.
    task automatic runCycle(input bit rst);
        @(negedge clk);
        checkAll();
        reset = rst;
        applyStimulus(rst);
        modelStep(rst);
        if (last_accept) begin
            pend_valid = 1'b0;
        end
    endtask

    initial begin
        bus.cfg_valid  = 1'b0;
        bus.cfg_ch     = '0;
        bus.cfg_mode   = '0;
        bus.cfg_level  = '0;
        bus.cfg_period = '0;
        for (int i = 0; i < 5; i++) runCycle(1'b1);
        for (int i = 0; i < 3000; i++) runCycle(1'b0);
        for (int i = 0; i < 4; i++) runCycle(1'b1);
        for (int i = 0; i < 3000; i++) runCycle(1'b0);
        @(negedge clk);
        checkAll();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_pwm_ctrl.md
Name: led_pwm_ctrl

Overview:
- Parametrised LED/GPIO output controller for NUM_CH channels. It replaces the fixed 4-bit GPIO-to-LED drive with per-channel modes: off, on, PWM dimming and blinking.
- Sits between the MicroBlaze GPIO/AXI-lite register shim and the board LED pins.
- Configuration arrives over a valid/ready write port. New settings are applied glitch-free, only at PWM frame boundaries.

Parameters:
- NUM_CH, 8, number of output channels (1..32).
- PWM_BITS, 8, PWM resolution; frame length is 2**PWM_BITS ticks.
- PRESCALE, 100, clk cycles per PWM tick (>=1).
- BLINK_BITS, 16, width of the blink period field, counted in PWM frames.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, synchronous active-high reset.
- cfg_valid, in, 1, config write request.
- cfg_ready, out, 1, controller can accept a write.
- cfg_ch, in, $clog2(NUM_CH) (min 1), target channel.
- cfg_mode, in, 2, 0=OFF 1=ON 2=PWM 3=BLINK.
- cfg_level, in, PWM_BITS, PWM duty level.
- cfg_period, in, BLINK_BITS, blink half-period in frames, minus 1.
- cfg_err, out, 1, one-cycle pulse when an accepted write targets cfg_ch >= NUM_CH.
- frame_start, out, 1, one-cycle pulse on the first tick of each PWM frame.
- led, out, NUM_CH, registered channel outputs.

Behaviour:
- Reset (synchronous, active-high)
  - Clears the prescaler, pwm_cnt, all shadow/active registers (mode OFF, level 0, period 0) and all blink counters/phases.
  - Outputs during reset and on the first cycle after: led=0, cfg_ready=0, cfg_err=0, frame_start=0.
  - cfg_ready rises on the first cycle after reset deasserts.
  - Reset mid-frame abandons pending shadow writes.
- Prescaler
  - Counts 0..PRESCALE-1; tick asserts when the count is PRESCALE-1.
  - On tick, pwm_cnt increments modulo 2**PWM_BITS.
  - frame_start is registered and pulses the cycle after the tick that wraps pwm_cnt to 0.
- Config handshake
  - A write is accepted when cfg_valid && cfg_ready.
  - On accept: the channel's shadow {mode, level, period} is written, and cfg_ready drops for exactly one cycle (write commit), then returns to 1.
  - cfg_valid must be held until accepted.
  - Out-of-range cfg_ch: the write is accepted, no state changes, and cfg_err pulses the following cycle.
  - Multiple writes to one channel within a frame: last write wins.
- Commit
  - On each internal frame wrap (pwm_cnt 2**PWM_BITS-1 -> 0 tick), active <= shadow for all channels simultaneously.
  - A write accepted on that same cycle is not in the shadow yet; it applies at the following frame.
  - A changed mode or period resets that channel's blink counter to 0 and blink phase to ON.
- Per-channel output (registered; led lags internal state by 1 cycle)
  - OFF: 0.
  - ON: 1.
  - PWM: pwm_cnt < eff_level. Level 0 gives constant 0; maximum level gives 1 for (2**PWM_BITS-1)/2**PWM_BITS of the frame. Full-on requires ON mode.
  - BLINK: phase ? (pwm_cnt < eff_level) : 0.
    - The blink counter increments at each frame wrap.
    - When the counter equals period, it clears and phase toggles.
    - Period 0 toggles every frame.
- Width rules: the comparison is unsigned PWM_BITS-wide; counters wrap silently.

Optional Feature:
- Macro: LED_PWM_CTRL_GAMMA_EN.
- Defined: eff_level = (level*level) >> PWM_BITS, computed with a 2*PWM_BITS-wide product and truncated. This gives perceptual dimming.
- Undefined: eff_level = level, and no multiplier is built.
- The handshake and all timing are identical in both builds.

Decomposition:
- Package led_pwm_pkg holds:
  - enum led_mode_t {LED_OFF, LED_ON, LED_PWM, LED_BLINK};
  - struct ch_cfg_t {mode, level, period}, with widths taken from package localparams that default to the parameter values.
- One sub-module, led_pwm_chan: per-channel shadow/active registers, blink counter/phase and output compare. It is instantiated NUM_CH times in a generate loop.
- The top keeps the prescaler, pwm_cnt and handshake logic.

Test Plan (PRESCALE=1, PWM_BITS=4, NUM_CH=4 unless noted):
1. Reset held 5 cycles, then released -> led=0 throughout; cfg_ready=0 in reset and on the first cycle after, then 1; frame_start first pulses 17 cycles after release.
2. Write ch0 PWM level=4 mid-frame -> led[0] unchanged until the next frame commit, then high exactly 4 of every 16 cycles, aligned to frame_start+1.
3. Write ch1 BLINK level=15 period=1 -> led[1] shows a 15/16 pattern for 2 frames, then 0 for 2 frames, repeating; cfg_ready low exactly 1 cycle after the accept.
4. Write cfg_ch=5 with NUM_CH=4, then cfg_ch=2 ON on the next ready -> cfg_err pulses once, no led change from the first write; led[2]=1 after the next commit.
5. Two writes to ch3 in one frame (PWM 8, then OFF), with the second accepted on the frame-wrap cycle -> the frame after shows PWM 8; the following frame shows OFF.
6. Gamma build, ch0 PWM level=8 -> eff_level=4, led[0] high 4 of 16 cycles; non-gamma build gives 8 of 16.
